// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 inverse cipher, one 32-bit InvSubBytes word per cycle via external S-box.
// Optional feature: define AES_DECIPHER_ABORT_EN to add the 'abort' input.
module aes_decipher_block (
  input  logic         clk,
  input  logic         reset,
`ifdef AES_DECIPHER_ABORT_EN
  input  logic         abort,
`endif
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  localparam logic [3:0] AES128_ROUNDS = 4'ha;
  localparam logic [3:0] AES256_ROUNDS = 4'he;

  typedef enum logic [1:0] {StIdle, StInit, StSbox, StMain} state_e;

  state_e       state_q, state_d;
  logic [127:0] block_q, block_d;
  logic [3:0]   round_q, round_d;
  logic [1:0]   sword_ctr_q, sword_ctr_d;
  logic         keylen_reg_q, keylen_reg_d;
  logic         ready_q, ready_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
    logic [7:0] b [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      b[i]  = w[31-8*i -: 8];
      x2    = xtime(b[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ b[i];
      mb[i] = x8 ^ x2 ^ b[i];
      md[i] = x8 ^ x4 ^ b[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = inv_mix_word(s[127-32*c -: 32]);
    return r;
  endfunction

  // Row r of column c takes the byte from column (c - r) mod 4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[127-32*c-8*rw -: 8] = s[127-32*((c-rw+4)%4)-8*rw -: 8];
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      block_q      <= '0;
      round_q      <= '0;
      sword_ctr_q  <= '0;
      keylen_reg_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      block_q      <= block_d;
      round_q      <= round_d;
      sword_ctr_q  <= sword_ctr_d;
      keylen_reg_q <= keylen_reg_d;
      ready_q      <= ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    block_d      = block_q;
    round_d      = round_q;
    sword_ctr_d  = sword_ctr_q;
    keylen_reg_d = keylen_reg_q;
    ready_d      = ready_q;
    sboxw        = '0;

    case (state_q)
      StIdle: begin
        if (next) begin
          round_d      = keylen ? AES256_ROUNDS : AES128_ROUNDS;
          keylen_reg_d = keylen;
          ready_d      = 1'b0;
          state_d      = StInit;
        end
      end
      StInit: begin
        block_d     = inv_shift_rows(block ^ round_key);
        round_d     = round_q - 4'd1;
        sword_ctr_d = '0;
        state_d     = StSbox;
      end
      StSbox: begin
        case (sword_ctr_q)
          2'd0: begin sboxw = block_q[127:96]; block_d[127:96] = new_sboxw; end
          2'd1: begin sboxw = block_q[95:64];  block_d[95:64]  = new_sboxw; end
          2'd2: begin sboxw = block_q[63:32];  block_d[63:32]  = new_sboxw; end
          default: begin sboxw = block_q[31:0]; block_d[31:0] = new_sboxw; end
        endcase
        sword_ctr_d = sword_ctr_q + 2'd1;
        if (sword_ctr_q == 2'd3) state_d = StMain;
      end
      StMain: begin
        if (round_q != 4'd0) begin
          block_d     = inv_shift_rows(inv_mix_columns(block_q ^ round_key));
          round_d     = round_q - 4'd1;
          sword_ctr_d = '0;
          state_d     = StSbox;
        end else begin
          block_d = block_q ^ round_key;
          ready_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef AES_DECIPHER_ABORT_EN
    // Abort scrubs partial state so no intermediate data leaks out on new_block.
    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      block_d     = '0;
      round_d     = '0;
      sword_ctr_d = '0;
      ready_d     = 1'b1;
    end
`endif
  end

  assign round     = round_q;
  assign new_block = block_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_aes_decipher_block.sv
// Directed bench for aes_decipher_block: FIPS-197 vectors with key-memory and inverse S-box models.
module tb_aes_decipher_block;

  logic         clk;
  logic         reset;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;
`ifdef AES_DECIPHER_ABORT_EN
  logic         abort;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox     [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] rk       [0:14];

  localparam logic [255:0] Key128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] Key256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] Ct128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Ct256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] Pt    = 128'h00112233445566778899aabbccddeeff;

  aes_decipher_block dut (
    .clk       (clk),
    .reset     (reset),
`ifdef AES_DECIPHER_ABORT_EN
    .abort     (abort),
`endif
    .next      (next),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw),
    .block     (block),
    .new_block (new_block),
    .ready     (ready)
  );

  assign round_key = rk[round];
  assign new_sboxw = {inv_sbox[sboxw[31:24]], inv_sbox[sboxw[23:16]],
                      inv_sbox[sboxw[15:8]], inv_sbox[sboxw[7:0]]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[a]     = s;
      inv_sbox[s] = 8'(a);
    end
  endtask

  task automatic expand(input logic [255:0] key, input bit aes256);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nk = aes256 ? 8 : 4;
    int nw = aes256 ? 60 : 44;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++)
      rk[r] = (4*r + 3 < nw) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready && n < 200);
  endtask

  // Full decipher of one vector: start, watch INIT, wait for completion, check latency and data.
  task automatic run_op(input string tag, input bit kl, input logic [127:0] ct, input int lat);
    int n;
    expand(kl ? Key256 : Key128, kl);
    keylen = kl;
    block  = ct;
    next   = 1'b1;
    tick();
    next = 1'b0;
    check({tag, "_busy"}, 128'(ready), 128'(0));
    check({tag, "_init_round"}, 128'(round), kl ? 128'(14) : 128'(10));
    check({tag, "_init_sboxw"}, 128'(sboxw), 128'(0));
    wait_ready(n);
    check({tag, "_latency"}, 128'(n), 128'(lat));
    check({tag, "_result"}, new_block, Pt);
    check({tag, "_final_round"}, 128'(round), 128'(0));
  endtask

  initial begin
    int n;
    logic [127:0] held;
    reset  = 1'b1;
    next   = 1'b0;
    keylen = 1'b0;
    block  = '0;
`ifdef AES_DECIPHER_ABORT_EN
    abort  = 1'b0;
`endif
    build_sbox();
    expand(Key128, 1'b0);
    tick();
    tick();
    check("rst_ready", 128'(ready), 128'(1));
    check("rst_block", new_block, 128'h0);
    check("rst_round", 128'(round), 128'(0));
    check("rst_sboxw", 128'(sboxw), 128'(0));
    reset = 1'b0;
    tick();

    run_op("c1_aes128", 1'b0, Ct128, 51);
    tick();
    check("c1_hold", new_block, Pt);
    run_op("c3_aes256", 1'b1, Ct256, 71);

    // Busy-time disturbances on next, keylen and block must be ignored.
    expand(Key128, 1'b0);
    keylen = 1'b0;
    block  = Ct128;
    next   = 1'b1;
    tick();
    next = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 5)  block  = Ct256;
      if (n == 10) next   = 1'b1;
      if (n == 11) next   = 1'b0;
      if (n == 20) keylen = 1'b1;
    end while (!ready && n < 200);
    check("ignore_latency", 128'(n), 128'(51));
    check("ignore_result", new_block, Pt);
    keylen = 1'b0;
    tick();

    // Reset in the middle of an operation.
    block = Ct128;
    next  = 1'b1;
    tick();
    next = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check("midrst_busy", 128'(ready), 128'(0));
    reset = 1'b1;
    tick();
    check("midrst_ready", 128'(ready), 128'(1));
    check("midrst_block", new_block, 128'h0);
    check("midrst_round", 128'(round), 128'(0));
    reset = 1'b0;
    tick();
    run_op("after_rst", 1'b0, Ct128, 51);

    // Back-to-back with next held high.
    expand(Key128, 1'b0);
    keylen = 1'b0;
    block  = Ct128;
    next   = 1'b1;
    tick();
    check("b2b_first_busy", 128'(ready), 128'(0));
    wait_ready(n);
    check("b2b_first_latency", 128'(n), 128'(51));
    check("b2b_first_result", new_block, Pt);
    expand(Key256, 1'b1);
    keylen = 1'b1;
    block  = Ct256;
    tick();
    check("b2b_restart", 128'(ready), 128'(0));
    check("b2b_restart_round", 128'(round), 128'(14));
    wait_ready(n);
    next = 1'b0;
    check("b2b_second_latency", 128'(n), 128'(71));
    check("b2b_second_result", new_block, Pt);
    held = new_block;
    tick();
    check("b2b_idle_ready", 128'(ready), 128'(1));
    check("b2b_idle_stable", new_block, held);

`ifdef AES_DECIPHER_ABORT_EN
    expand(Key128, 1'b0);
    keylen = 1'b0;
    block  = Ct128;
    next   = 1'b1;
    tick();
    next = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    check("abort_busy", 128'(ready), 128'(0));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_ready", 128'(ready), 128'(1));
    check("abort_block", new_block, 128'h0);
    check("abort_round", 128'(round), 128'(0));
    run_op("after_abort", 1'b0, Ct128, 51);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
